// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front-end: the per-channel
// debounce state encoding and the board's button index map.
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_U = 2;
    localparam int BTN_D = 3;
    localparam int BTN_C = 4;

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchronizer, debounce FSM and auto-repeat timer.
// A single counter serves both debounce and repeat, since they never overlap.
module button_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 400000,
    parameter int REPEAT_DELAY    = 20000000,
    parameter int REPEAT_RATE     = 4000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw,
    output logic       btn,
    output logic       btn_dn,
    output logic       btn_up,
    output logic       btn_rpt,
    output logic [1:0] state
);

    localparam logic [1:0] S_RELEASED     = RELEASED;
    localparam logic [1:0] S_PRESS_WAIT   = PRESS_WAIT;
    localparam logic [1:0] S_PRESSED      = PRESSED;
    localparam logic [1:0] S_RELEASE_WAIT = RELEASE_WAIT;

    localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_C  = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
    localparam int CW     = $clog2(MAX_C) + 1;

    localparam logic          RPT_EN    = (REPEAT_DELAY > 0);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DLY_LAST  = CW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rpt_on_q, rpt_on_d;
    logic          btn_q, btn_d;
    logic          dn_q, dn_d;
    logic          up_q, up_d;
    logic          rpt_q, rpt_d;

    always_comb begin
        s1_d     = raw;
        s2_d     = s1_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        rpt_on_d = rpt_on_q;
        btn_d    = btn_q;
        dn_d     = 1'b0;
        up_d     = 1'b0;
        rpt_d    = 1'b0;
        case (state_q)
            S_RELEASED: begin
                if (s2_q) begin
                    state_d = S_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d = S_RELEASED;
                end else if (cnt_q == DB_LAST) begin
                    state_d  = S_PRESSED;
                    btn_d    = 1'b1;
                    dn_d     = 1'b1;
                    cnt_d    = '0;
                    rpt_on_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PRESSED: begin
                if (!s2_q) begin
                    state_d = S_RELEASE_WAIT;
                    cnt_d   = '0;
                end else if (RPT_EN) begin
                    // rpt_on_q selects between the initial delay and the steady rate
                    if ((!rpt_on_q && cnt_q == DLY_LAST) || (rpt_on_q && cnt_q == RATE_LAST)) begin
                        rpt_d    = 1'b1;
                        rpt_on_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_RELEASE_WAIT: begin
                if (s2_q) begin
                    state_d  = S_PRESSED;
                    cnt_d    = '0;
                    rpt_on_d = 1'b0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = S_RELEASED;
                    btn_d   = 1'b0;
                    up_d    = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            state_q  <= S_RELEASED;
            cnt_q    <= '0;
            rpt_on_q <= 1'b0;
            btn_q    <= 1'b0;
            dn_q     <= 1'b0;
            up_q     <= 1'b0;
            rpt_q    <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rpt_on_q <= rpt_on_d;
            btn_q    <= btn_d;
            dn_q     <= dn_d;
            up_q     <= up_d;
            rpt_q    <= rpt_d;
        end
    end

    assign btn     = btn_q;
    assign btn_dn  = dn_q;
    assign btn_up  = up_q;
    assign btn_rpt = rpt_q;
    assign state   = state_q;

endmodule

// File: rtl/button_conditioner.sv
// Five-direction push-button front-end: NBTN identical, independent channels.
// dbg_state packs each channel's FSM state, two bits per channel.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int NBTN            = 5,
    parameter int DEBOUNCE_CYCLES = 400000,
    parameter int REPEAT_DELAY    = 20000000,
    parameter int REPEAT_RATE     = 4000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NBTN-1:0]     raw,
    output logic [NBTN-1:0]     btn,
    output logic [NBTN-1:0]     btn_dn,
    output logic [NBTN-1:0]     btn_up,
    output logic [NBTN-1:0]     btn_rpt,
    output logic [2*NBTN-1:0]   dbg_state
);

    for (genvar i = 0; i < NBTN; i++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .raw    (raw[i]),
            .btn    (btn[i]),
            .btn_dn (btn_dn[i]),
            .btn_up (btn_up[i]),
            .btn_rpt(btn_rpt[i]),
            .state  (dbg_state[2*i +: 2])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat timing;
// each cycle's expected outputs are queued with the stimulus and checked after the edge.
module tb_button_conditioner;
    import btn_pkg::*;

    localparam int NBTN = 5;
    localparam int DB   = 4;
    localparam int RD   = 10;
    localparam int RR   = 3;

    localparam logic [4:0] ML = 5'd1 << BTN_L;
    localparam logic [4:0] MR = 5'd1 << BTN_R;
    localparam logic [4:0] MU = 5'd1 << BTN_U;
    localparam logic [4:0] MD = 5'd1 << BTN_D;
    localparam logic [4:0] MC = 5'd1 << BTN_C;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  raw;
    logic [4:0]  btn, btn_dn, btn_up, btn_rpt;
    logic [9:0]  dbg_state;

    logic [19:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    string       tag = "reset";

    button_conditioner #(
        .NBTN(NBTN), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst(rst), .raw(raw), .btn(btn), .btn_dn(btn_dn),
        .btn_up(btn_up), .btn_rpt(btn_rpt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus and queue the outputs expected after its edge.
    task automatic cyc(input logic [4:0] r, input logic [4:0] eb, input logic [4:0] ed,
                       input logic [4:0] eu, input logic [4:0] er);
        raw = r;
        exp_q.push_back({eb, ed, eu, er});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        logic [19:0] e;
        logic [19:0] obs;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = {btn, btn_dn, btn_up, btn_rpt};
            checks++;
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: btn/dn/up/rpt got %h expected %h", tag, obs, e);
            end
        end
    end

    initial begin
        logic [4:0] r, eb, ed, eu, er;

        rst = 1'b1;
        raw = '0;
        for (int i = 0; i < 3; i++) cyc('0, '0, '0, '0, '0);
        checks++;
        assert (dbg_state === '0) else begin
            errors++;
            $error("FAIL reset_state: got %h expected %h", dbg_state, 10'h0);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) cyc('0, '0, '0, '0, '0);

        // Left: press, hold briefly, release (no repeat reached)
        tag = "press_release_l";
        for (int i = 0; i <= 16; i++) begin
            r  = (i <= 7) ? ML : 5'd0;
            eb = (i >= 6 && i < 14) ? ML : 5'd0;
            ed = (i == 6) ? ML : 5'd0;
            eu = (i == 14) ? ML : 5'd0;
            cyc(r, eb, ed, eu, 5'd0);
            if (i == 7) begin
                checks++;
                assert (dbg_state[2*BTN_L +: 2] === 2'(PRESSED)) else begin
                    errors++;
                    $error("FAIL state_pressed: got %0d expected %0d", dbg_state[2*BTN_L +: 2], 2'(PRESSED));
                end
            end
            if (i == 11) begin
                checks++;
                assert (dbg_state[2*BTN_L +: 2] === 2'(RELEASE_WAIT)) else begin
                    errors++;
                    $error("FAIL state_relwait: got %0d expected %0d", dbg_state[2*BTN_L +: 2], 2'(RELEASE_WAIT));
                end
            end
        end

        // Up: glitches of 3 and of DB cycles are both filtered
        tag = "glitch3_u";
        for (int i = 0; i < 10; i++) cyc((i < 3) ? MU : 5'd0, '0, '0, '0, '0);
        tag = "glitch4_u";
        for (int i = 0; i < 10; i++) cyc((i < 4) ? MU : 5'd0, '0, '0, '0, '0);

        // Centre: long hold with auto-repeat, then release
        tag = "repeat_c";
        for (int i = 0; i <= 45; i++) begin
            r  = (i <= 36) ? MC : 5'd0;
            eb = (i >= 6 && i < 43) ? MC : 5'd0;
            ed = (i == 6) ? MC : 5'd0;
            eu = (i == 43) ? MC : 5'd0;
            er = (i >= 16 && i <= 38 && ((i - 16) % 3) == 0) ? MC : 5'd0;
            cyc(r, eb, ed, eu, er);
        end

        // Right: release with a 2-cycle bounce back high
        tag = "bounce_r";
        for (int i = 0; i <= 22; i++) begin
            r  = (i <= 9 || i == 12 || i == 13) ? MR : 5'd0;
            eb = (i >= 6 && i < 20) ? MR : 5'd0;
            ed = (i == 6) ? MR : 5'd0;
            eu = (i == 20) ? MR : 5'd0;
            cyc(r, eb, ed, eu, 5'd0);
        end

        // Up: reset during debounce, then again just before the first repeat
        tag = "reset_mid_u";
        for (int i = 0; i <= 26; i++) begin
            rst = (i == 3 || i == 4 || i == 19 || i == 20);
            r   = (i <= 20) ? MU : 5'd0;
            eb  = (i >= 11 && i < 19) ? MU : 5'd0;
            ed  = (i == 11) ? MU : 5'd0;
            cyc(r, eb, ed, 5'd0, 5'd0);
            if (i == 4) begin
                checks++;
                assert (dbg_state === '0) else begin
                    errors++;
                    $error("FAIL state_in_reset: got %h expected %h", dbg_state, 10'h0);
                end
            end
        end
        rst = 1'b0;

        // Right and down pressed and released together
        tag = "simul_rd";
        for (int i = 0; i <= 16; i++) begin
            r  = (i <= 8) ? (MR | MD) : 5'd0;
            eb = (i >= 6 && i < 15) ? (MR | MD) : 5'd0;
            ed = (i == 6) ? (MR | MD) : 5'd0;
            eu = (i == 15) ? (MR | MD) : 5'd0;
            cyc(r, eb, ed, eu, 5'd0);
        end

        tag = "idle";
        for (int i = 0; i < 3; i++) cyc('0, '0, '0, '0, '0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end for the five-direction push buttons. Converts raw, asynchronous, bouncing pad levels into clean per-button signals for the control core's input-mode stage: a debounced level, a one-cycle press pulse, a one-cycle release pulse and a one-cycle auto-repeat pulse. It sits between the board pins and the per-button input-mode instances. All channels are identical and independent.

## Interface
- NBTN, 5, number of button channels (bit 0 = L, 1 = R, 2 = U, 3 = D, 4 = C).
- DEBOUNCE_CYCLES, 400000, stable-input cycles required to accept a transition (10 ms at 40 MHz); must be ≥ 1.
- REPEAT_DELAY, 20000000, cycles from accepted press to the first repeat pulse; 0 disables repeat.
- REPEAT_RATE, 4000000, cycles between subsequent repeat pulses; must be ≥ 1.
- clk  in  1  pixel/system clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- raw  in  NBTN  asynchronous pad levels, 1 = pressed.
- btn  out  NBTN  debounced level.
- btn_dn  out  NBTN  one-cycle pulse on accepted press.
- btn_up  out  NBTN  one-cycle pulse on accepted release.
- btn_rpt  out  NBTN  one-cycle auto-repeat pulse while held.

## Operation
- Per channel: 2-flop synchronizer (s1 → s2), then a 4-state FSM on s2: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- RELEASED: if s2 = 1, go to PRESS_WAIT and clear cnt.
- PRESS_WAIT: if s2 = 0, return to RELEASED; nothing is emitted.
  - Else, if cnt = DEBOUNCE_CYCLES−1, go to PRESSED, set btn, pulse btn_dn and clear cnt.
  - Else, cnt+1.
- PRESSED: if s2 = 0, go to RELEASE_WAIT and clear cnt.
  - Else, the repeat counter runs. With REPEAT_DELAY > 0, the first btn_rpt fires REPEAT_DELAY cycles after btn_dn, then every REPEAT_RATE cycles.
- RELEASE_WAIT: if s2 = 1, return to PRESSED. btn stays 1. The repeat schedule restarts from zero; no new btn_dn.
  - Else, if cnt = DEBOUNCE_CYCLES−1, go to RELEASED, clear btn and pulse btn_up.
  - Else, cnt+1.
- Counter width: $clog2 of the largest of DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE, plus 1. Counters never wrap, because they are cleared at every terminal compare.
- btn_dn, btn_up and btn_rpt are mutually exclusive per channel in any cycle. btn_rpt never fires in the btn_dn cycle.
- Channels are fully independent; simultaneous presses on several channels produce pulses in the same cycle.

## Timing
- All outputs are registered.
- Reset values: btn = 0, btn_dn = 0, btn_up = 0, btn_rpt = 0. Synchronizers = 0, FSM = RELEASED, counters = 0.
- Press latency: raw goes high before edge k and stays high. Then btn = 1 and btn_dn = 1 are visible after edge k + 2 + DEBOUNCE_CYCLES. btn_dn lasts exactly one cycle.
- Release latency is symmetric: btn = 0 and btn_up = 1 after edge k + 2 + DEBOUNCE_CYCLES.
- Glitches shorter than DEBOUNCE_CYCLES consecutive s2 cycles produce no output change.
- Button held through reset: after rst falls, it is treated as a fresh press, with btn_dn after 2 + DEBOUNCE_CYCLES cycles.
- Reset mid-debounce or mid-repeat aborts immediately; no pending pulse is emitted.

## Structure
- Shared package btn_pkg holds:
  - the channel state enum (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT);
  - the button index constants (BTN_L = 0 … BTN_C = 4).
- Sub-module button_channel: synchronizer, FSM, debounce and repeat counters for one bit. The top instantiates NBTN of them in a generate loop.

## Test plan
- Test parameters: DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 10, REPEAT_RATE = 3.
- raw[0] rises at edge 10 and holds → btn[0] = 1 and btn_dn[0] = 1 after edge 16; btn_dn[0] = 0 after edge 17; other bits 0.
- raw[2] high for 3 cycles, then low → btn, btn_dn, btn_up and btn_rpt all stay 0.
- raw[4] held 30 cycles after acceptance at edge N → btn_rpt[4] pulses after edges N+10, N+13, N+16, … while held.
- Release with a 2-cycle bounce → btn stays 1, no btn_up. Stable low then gives btn_up one cycle, 6 cycles after the last rising-to-low edge.
- rst asserted during PRESS_WAIT with raw held → all outputs 0 during reset; btn_dn 6 cycles after rst deasserts.
- raw[1] and raw[3] rise on the same edge → btn_dn[1] and btn_dn[3] pulse in the same cycle.
